fp16_dot_mac: RTL and testbench

//  Datapath sequencer for the RESULT phase. On start, it reads N_ELEM operand pairs from

---
 rtl/fp16_dot_mac.sv | 229 ++++++++++++++++++++++
 tb/tb_fp16_dot_mac.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_dot_mac.sv
// fp16_dot_mac: sequential binary16 dot-product engine. Reads N_ELEM operand pairs
// from the shared SRAM and accumulates sum(A[i]*B[i]) with flush-to-zero and truncation.
module fp16_dot_mac #(
  parameter int N_ELEM = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       a_data,
  input  logic [15:0]       b_data,
  output logic              busy,
  output logic [15:0]       result,
  output logic              result_valid,
  output logic              ovf,
  output logic              inv
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_MUL, S_ADD, S_DONE} state_e;
  typedef struct packed {
    logic [15:0] val;
    logic        ovf;
    logic        inv;
  } fp_res_t;

  localparam logic [15:0] QNAN = 16'h7E00;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] == 10'h000);
  endfunction

  // Subnormals are flushed, so a zero exponent field means zero.
  function automatic logic is_zero(input logic [15:0] x);
    return x[14:10] == 5'h00;
  endfunction

  function automatic fp_res_t fp_mul(input logic [15:0] a, input logic [15:0] b);
    fp_res_t           r;
    logic              sgn;
    logic [21:0]       p;
    logic signed [7:0] e;
    logic [9:0]        frac;
    r    = '0;
    sgn  = a[15] ^ b[15];
    p    = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e    = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15
         + $signed({7'b0000000, p[21]});
    frac = 10'(p >> (p[21] ? 5'd11 : 5'd10));
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) begin
      r.val = QNAN;
      r.inv = 1'b1;
    end else if (is_inf(a) || is_inf(b)) begin
      r.val = {sgn, 5'h1f, 10'h000};
    end else if (is_zero(a) || is_zero(b)) begin
      r.val = 16'h0000;
    end else if (e >= 8'sd31) begin
      r.val = {sgn, 5'h1f, 10'h000};
      r.ovf = 1'b1;
    end else if (e <= 8'sd0) begin
      r.val = 16'h0000;
    end else begin
      r.val = {sgn, e[4:0], frac};
    end
    return r;
  endfunction

  function automatic fp_res_t fp_add(input logic [15:0] x, input logic [15:0] y);
    fp_res_t           r;
    logic [15:0]       big, sml;
    logic [4:0]        d;
    logic [11:0]       lm, sm, dif, nrm;
    logic [12:0]       sum;
    logic [3:0]        lz;
    logic signed [7:0] e;
    r = '0;
    if (x[14:0] >= y[14:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    // One guard bit below the LSB survives alignment; it only matters when
    // cancellation shifts the difference left.
    d   = big[14:10] - sml[14:10];
    lm  = {1'b1, big[9:0], 1'b0};
    sm  = (d >= 5'd12) ? 12'h000 : ({1'b1, sml[9:0], 1'b0} >> d);
    sum = {1'b0, lm} + {1'b0, sm};
    dif = lm - sm;
    lz  = 4'd0;
    for (int i = 0; i < 12; i++) if (dif[i]) lz = 4'(11 - i);
    nrm = dif << lz;
    e   = 8'sd0;
    if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && (x[15] != y[15]))) begin
      r.val = QNAN;
      r.inv = 1'b1;
    end else if (is_inf(x)) begin
      r.val = x;
    end else if (is_inf(y)) begin
      r.val = y;
    end else if (is_zero(x) && is_zero(y)) begin
      r.val = 16'h0000;
    end else if (is_zero(x)) begin
      r.val = y;
    end else if (is_zero(y)) begin
      r.val = x;
    end else if (big[15] == sml[15]) begin
      e = $signed({3'b000, big[14:10]}) + $signed({7'b0000000, sum[12]});
      if (e >= 8'sd31) begin
        r.val = {big[15], 5'h1f, 10'h000};
        r.ovf = 1'b1;
      end else begin
        r.val = {big[15], e[4:0], 10'(sum >> (sum[12] ? 4'd2 : 4'd1))};
      end
    end else if (dif == 12'h000) begin
      r.val = 16'h0000;
    end else begin
      e = $signed({3'b000, big[14:10]}) - $signed({4'b0000, lz});
      if (e <= 8'sd0) r.val = 16'h0000;
      else            r.val = {big[15], e[4:0], 10'(nrm >> 1)};
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, rd_addr_q, rd_addr_d;
  logic [15:0]       acc_q, acc_d, prod_q, prod_d, result_q, result_d;
  logic              rd_en_q, rd_en_d, busy_q, busy_d;
  logic              result_valid_q, result_valid_d;
  logic              ovf_q, ovf_d, inv_q, inv_d;
  fp_res_t           mul_r, add_r;
  logic              last;

  always_comb begin
    mul_r = fp_mul(a_data, b_data);
    add_r = fp_add(acc_q, prod_q);
    last  = (idx_q == ADDR_W'(N_ELEM - 1));
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    prod_d         = prod_q;
    result_d       = result_q;
    rd_addr_d      = rd_addr_q;
    ovf_d          = ovf_q;
    inv_d          = inv_q;
    rd_en_d        = 1'b0;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_READ;
        idx_d     = '0;
        acc_d     = 16'h0000;
        ovf_d     = 1'b0;
        inv_d     = 1'b0;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      S_READ: state_d = S_MUL;
      S_MUL: begin
        prod_d  = mul_r.val;
        ovf_d   = ovf_q | mul_r.ovf;
        inv_d   = inv_q | mul_r.inv;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d = add_r.val;
        ovf_d = ovf_q | add_r.ovf;
        inv_d = inv_q | add_r.inv;
        if (last) begin
          state_d        = S_DONE;
          result_d       = add_r.val;
          result_valid_d = 1'b1;
        end else begin
          idx_d     = idx_q + ADDR_W'(1);
          state_d   = S_READ;
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q + ADDR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      acc_q          <= 16'h0000;
      prod_q         <= 16'h0000;
      result_q       <= 16'h0000;
      rd_addr_q      <= '0;
      rd_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      inv_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      prod_q         <= prod_d;
      result_q       <= result_d;
      rd_addr_q      <= rd_addr_d;
      rd_en_q        <= rd_en_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      inv_q          <= inv_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign ovf          = ovf_q;
  assign inv          = inv_q;
endmodule

// File: tb/tb_fp16_dot_mac.sv
// tb_fp16_dot_mac: directed + random runs of fp16_dot_mac against a value-level
// binary16 model (integer significand * 2^exp, truncating normalisation).
module tb_fp16_dot_mac;
  localparam int N    = 8;
  localparam int AW   = 4;
  localparam int LAST = 3 * N + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   a_data = 16'h0000;
  logic [15:0]   b_data = 16'h0000;
  logic          busy, result_valid, ovf, inv;
  logic [15:0]   result;

  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          m_ovf, m_inv;

  fp16_dot_mac #(.N_ELEM(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_data(a_data), .b_data(b_data), .busy(busy), .result(result),
    .result_valid(result_valid), .ovf(ovf), .inv(inv)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM; data outside a read slot is garbage.
  always @(posedge clk) begin
    a_data <= rd_en ? mem_a[rd_addr[2:0]] : 16'($urandom);
    b_data <= rd_en ? mem_b[rd_addr[2:0]] : 16'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit f_nan(input logic [15:0] x);
    return x[14:10] == 5'h1f && x[9:0] != 10'h0;
  endfunction
  function automatic bit f_inf(input logic [15:0] x);
    return x[14:10] == 5'h1f && x[9:0] == 10'h0;
  endfunction
  function automatic bit f_zero(input logic [15:0] x);
    return x[14:10] == 5'h00;
  endfunction

  // value = r * 2^e, r > 0 integer; truncate to 11 significant bits
  function automatic logic [15:0] m_pack(input bit s, input int r, input int e);
    int b;
    if (r == 0) return 16'h0000;
    while (r >= 2048) begin r = r >> 1; e++; end
    while (r < 1024) begin r = r << 1; e--; end
    b = e + 25;
    if (b >= 31) begin m_ovf = 1'b1; return {s, 5'h1f, 10'h000}; end
    if (b <= 0) return 16'h0000;
    return {s, 5'(b), 10'(r)};
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    bit s;
    if (f_nan(a) || f_nan(b) || (f_inf(a) && f_zero(b)) || (f_inf(b) && f_zero(a))) begin
      m_inv = 1'b1;
      return 16'h7E00;
    end
    s = a[15] ^ b[15];
    if (f_inf(a) || f_inf(b)) return {s, 5'h1f, 10'h000};
    if (f_zero(a) || f_zero(b)) return 16'h0000;
    return m_pack(s, (1024 + int'(a[9:0])) * (1024 + int'(b[9:0])),
                  int'(a[14:10]) + int'(b[14:10]) - 50);
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] l, s;
    int d, lv, sv;
    if (f_nan(x) || f_nan(y) || (f_inf(x) && f_inf(y) && x[15] != y[15])) begin
      m_inv = 1'b1;
      return 16'h7E00;
    end
    if (f_inf(x)) return x;
    if (f_inf(y)) return y;
    if (f_zero(x)) return f_zero(y) ? 16'h0000 : y;
    if (f_zero(y)) return x;
    if (x[14:0] >= y[14:0]) begin l = x; s = y; end
    else begin l = y; s = x; end
    d  = int'(l[14:10]) - int'(s[14:10]);
    lv = (1024 + int'(l[9:0])) * 2;
    sv = (d >= 12) ? 0 : (((1024 + int'(s[9:0])) * 2) >> d);
    return m_pack(l[15], (l[15] == s[15]) ? lv + sv : lv - sv, int'(l[14:10]) - 26);
  endfunction

  function automatic logic [15:0] model();
    logic [15:0] acc;
    acc   = 16'h0000;
    m_ovf = 1'b0;
    m_inv = 1'b0;
    for (int i = 0; i < N; i++) acc = m_add(acc, m_mul(mem_a[i], mem_b[i]));
    return acc;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [15:0] sp [7];
    int k;
    sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01, 16'h0001, 16'h7BFF};
    k  = $urandom_range(0, 39);
    if (k < 7) return sp[k];
    if (k < 12) return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
  endfunction

  task automatic load(input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] fill);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = fill;
      mem_b[i] = fill;
    end
    mem_a[0] = a0; mem_a[1] = a1; mem_b[0] = b0; mem_b[1] = b1;
  endtask

  // Start in cycle 0, observe cycles 1..LAST; x1/x2 re-pulse start in those cycles.
  task automatic do_run(input string tag, input int x1, input int x2, input bit chain, input int want);
    logic [15:0] er;
    bit eo, ei;
    er = model();
    eo = m_ovf;
    ei = m_inv;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      start = (c == x1) || (c == x2);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rv"}, result_valid, c == LAST);
      chk({tag, "_rd_en"}, rd_en, (c % 3 == 1) && (c < LAST));
      if (c % 3 == 1 && c < LAST) chk({tag, "_rd_addr"}, rd_addr, (c - 1) / 3);
      if (c == LAST) begin
        chk({tag, "_result"}, result, er);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_inv"}, inv, ei);
        if (want >= 0) chk({tag, "_const"}, result, want[15:0]);
      end
    end
    if (!chain) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_rv"}, result_valid, 0);
        chk({tag, "_hold_result"}, result, er);
        chk({tag, "_hold_flags"}, {ovf, inv}, {eo, ei});
      end
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_outs", {result, result_valid, ovf, inv}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    load(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    do_run("t1", -1, -1, 0, 16'h4800);
    load(16'h4000, 16'h4200, 16'h4200, 16'h3800, 16'h0000);
    do_run("t2", -1, -1, 0, 16'h4780);
    load(16'h7BFF, 16'h0000, 16'h4000, 16'h0000, 16'h0000);
    do_run("t3_ovf", -1, -1, 0, 16'h7C00);
    load(16'h7C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_run("t3_inv", -1, -1, 0, 16'h7E00);
    load(16'h3C00, 16'hBC00, 16'h3C00, 16'h3C00, 16'h0000);
    do_run("t4_cancel", -1, -1, 0, 16'h0000);
    load(16'h0001, 16'h4000, 16'h4400, 16'h4000, 16'h0000);
    do_run("t4_subn", -1, -1, 0, 16'h4400);

    load(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    do_run("t5", 5, LAST, 1, 16'h4800);
    load(16'h4000, 16'h4200, 16'h4200, 16'h3800, 16'h0000);
    do_run("t5_next", -1, -1, 0, 16'h4780);

    load(16'h7C00, 16'h0000, 16'h0000, 16'h0000, 16'h3C00);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t6_pre_inv", inv, 1);
    chk("t6_pre_rd", {rd_en, rd_addr}, {1'b1, 4'd3});
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_ctl", {busy, rd_en, result_valid, ovf, inv}, 0);
    chk("t6_rst_rd_addr", rd_addr, 0);
    chk("t6_rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_quiet", {busy, result_valid}, 0);
    end
    load(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    do_run("t6_t1", -1, -1, 0, 16'h4800);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++) begin
        mem_a[i] = rnd_fp();
        mem_b[i] = rnd_fp();
      end
      do_run("rnd", -1, -1, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
